// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-cache read port and the IF/ID register.
// A three-state FSM tracks outstanding I-cache misses and remembers redirects that arrive during one.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        IFIDWrite,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ICACHE_ren,
   output logic [31:0] ICACHE_addr,
   input  logic        ICACHE_stall,
   input  logic [31:0] ICACHE_rdata,
   output logic [31:0] PC,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCplus4,
   output logic        IFID_Valid,
   output logic        fetch_stall,
   output logic [31:0] miss_cycles
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MISS       = 2'd1,
      MISS_REDIR = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcplus4_q, pcplus4_d;
   logic        valid_q, valid_d;
   logic [31:0] miss_q, miss_d;
   logic [31:0] pc_plus4;
   logic [31:0] redir_tgt;
   logic [31:0] pend_tgt;

   assign pc_plus4  = pc_q + 32'd4;
   assign redir_tgt = {redirect_pc[31:2], 2'b00};
   assign pend_tgt  = {pend_pc_q[31:2], 2'b00};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      miss_d    = miss_q;

      case (state_q)
         RUN, MISS: begin
            if (!ICACHE_stall) begin
               state_d = RUN;
               if (redirect_valid) begin
                  // A taken redirect squashes the word just fetched, even under an IF/ID hold.
                  pc_d    = redir_tgt;
                  instr_d = 32'h0;
                  valid_d = 1'b0;
               end else begin
                  if (IFIDWrite) begin
                     instr_d   = ICACHE_rdata;
                     pcplus4_d = pc_plus4;
                     valid_d   = 1'b1;
                  end
                  if (PCWrite) begin
                     pc_d = pc_plus4;
                  end
               end
            end else begin
               if (IFIDWrite) begin
                  instr_d = 32'h0;
                  valid_d = 1'b0;
               end
               if (redirect_valid) begin
                  pend_pc_d = redirect_pc;
                  state_d   = MISS_REDIR;
               end else begin
                  state_d = MISS;
               end
            end
         end
         MISS_REDIR: begin
            if (!ICACHE_stall) begin
               // The returned word belongs to the abandoned path and is dropped.
               state_d = RUN;
               instr_d = 32'h0;
               valid_d = 1'b0;
               pc_d    = redirect_valid ? redir_tgt : pend_tgt;
            end else begin
               if (IFIDWrite) begin
                  instr_d = 32'h0;
                  valid_d = 1'b0;
               end
               if (redirect_valid) begin
                  pend_pc_d = redirect_pc;
               end
            end
         end
         default: state_d = RUN;
      endcase

      if (ICACHE_ren && ICACHE_stall && (miss_q != 32'hFFFF_FFFF)) begin
         miss_d = miss_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         pend_pc_q <= 32'h0;
         instr_q   <= 32'h0;
         pcplus4_q <= 32'h0;
         valid_q   <= 1'b0;
         miss_q    <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
         miss_q    <= miss_d;
      end
   end

   assign ICACHE_ren   = ~rst;
   assign ICACHE_addr  = pc_q;
   assign PC           = pc_q;
   assign IFID_Instr   = instr_q;
   assign IFID_PCplus4 = pcplus4_q;
   assign IFID_Valid   = valid_q;
   assign fetch_stall  = (state_q != RUN);
   assign miss_cycles  = miss_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the main pipeline scenarios
// plus hand-written sequences for reset during a pending-redirect miss and PC wrap.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ICACHE_ren;
   logic [31:0] ICACHE_addr;
   logic        ICACHE_stall;
   logic [31:0] ICACHE_rdata;
   logic [31:0] PC;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PCplus4;
   logic        IFID_Valid;
   logic        fetch_stall;
   logic [31:0] miss_cycles;

   int n_checks;
   int n_pass;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .PCWrite        (PCWrite),
      .IFIDWrite      (IFIDWrite),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ICACHE_ren     (ICACHE_ren),
      .ICACHE_addr    (ICACHE_addr),
      .ICACHE_stall   (ICACHE_stall),
      .ICACHE_rdata   (ICACHE_rdata),
      .PC             (PC),
      .IFID_Instr     (IFID_Instr),
      .IFID_PCplus4   (IFID_PCplus4),
      .IFID_Valid     (IFID_Valid),
      .fetch_stall    (fetch_stall),
      .miss_cycles    (miss_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: a distinct non-zero word per address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   assign ICACHE_rdata = mem(ICACHE_addr);

   typedef struct {
      logic        pw;
      logic        iw;
      logic        rv;
      logic [31:0] rpc;
      logic        st;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_v;
      logic [31:0] e_p4;
      logic        e_fs;
      logic [31:0] e_miss;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic pw, input logic iw, input logic rv, input logic [31:0] rpc,
                      input logic st, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic e_v, input logic [31:0] e_p4, input logic e_fs,
                      input logic [31:0] e_miss);
      vec_t v;
      v.pw = pw; v.iw = iw; v.rv = rv; v.rpc = rpc; v.st = st;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_v = e_v; v.e_p4 = e_p4;
      v.e_fs = e_fs; v.e_miss = e_miss;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic pw, input logic iw, input logic rv, input logic [31:0] rpc,
                        input logic st);
      PCWrite = pw; IFIDWrite = iw; redirect_valid = rv; redirect_pc = rpc; ICACHE_stall = st;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      #2;
      chk("ren_in_reset", {31'h0, ICACHE_ren}, 32'h0);
      step();
      chk("rst_pc", PC, 32'h0);
      chk("rst_instr", IFID_Instr, 32'h0);
      chk("rst_p4", IFID_PCplus4, 32'h0);
      chk("rst_valid", {31'h0, IFID_Valid}, 32'h0);
      chk("rst_fstall", {31'h0, fetch_stall}, 32'h0);
      chk("rst_miss", miss_cycles, 32'h0);
      rst = 1'b0;
      #1;
      chk("ren_run", {31'h0, ICACHE_ren}, 32'h1);

      //   pw   iw   rv   rpc           st    e_pc          e_instr          v    e_p4     fs   miss
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h4,        mem(32'h0),      1'b1,32'h4,   1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h8,        mem(32'h4),      1'b1,32'h8,   1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'hC,        mem(32'h8),      1'b1,32'hC,   1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h10,       mem(32'hC),      1'b1,32'h10,  1'b0,32'd0);
      add(1'b0,1'b0,1'b0,32'h0,        1'b0, 32'h10,       mem(32'hC),      1'b1,32'h10,  1'b0,32'd0);
      add(1'b0,1'b0,1'b0,32'h0,        1'b0, 32'h10,       mem(32'hC),      1'b1,32'h10,  1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h14,       mem(32'h10),     1'b1,32'h14,  1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h18,       mem(32'h14),     1'b1,32'h18,  1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h1C,       mem(32'h18),     1'b1,32'h1C,  1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h20,       mem(32'h1C),     1'b1,32'h20,  1'b0,32'd0);
      add(1'b1,1'b1,1'b1,32'h40,       1'b0, 32'h40,       32'h0,           1'b0,32'h0,   1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h44,       mem(32'h40),     1'b1,32'h44,  1'b0,32'd0);
      add(1'b1,1'b1,1'b1,32'h83,       1'b0, 32'h80,       32'h0,           1'b0,32'h0,   1'b0,32'd0);
      add(1'b1,1'b1,1'b0,32'h0,        1'b1, 32'h80,       32'h0,           1'b0,32'h0,   1'b1,32'd1);
      add(1'b1,1'b1,1'b0,32'h0,        1'b1, 32'h80,       32'h0,           1'b0,32'h0,   1'b1,32'd2);
      add(1'b1,1'b1,1'b0,32'h0,        1'b1, 32'h80,       32'h0,           1'b0,32'h0,   1'b1,32'd3);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h84,       mem(32'h80),     1'b1,32'h84,  1'b0,32'd3);
      add(1'b1,1'b1,1'b1,32'h80,       1'b0, 32'h80,       32'h0,           1'b0,32'h0,   1'b0,32'd3);
      add(1'b1,1'b1,1'b0,32'h0,        1'b1, 32'h80,       32'h0,           1'b0,32'h0,   1'b1,32'd4);
      add(1'b1,1'b1,1'b1,32'h200,      1'b1, 32'h80,       32'h0,           1'b0,32'h0,   1'b1,32'd5);
      add(1'b1,1'b1,1'b0,32'h0,        1'b1, 32'h80,       32'h0,           1'b0,32'h0,   1'b1,32'd6);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h200,      32'h0,           1'b0,32'h0,   1'b0,32'd6);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h204,      mem(32'h200),    1'b1,32'h204, 1'b0,32'd6);
      add(1'b1,1'b0,1'b0,32'h0,        1'b1, 32'h204,      mem(32'h200),    1'b1,32'h204, 1'b1,32'd7);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h208,      mem(32'h204),    1'b1,32'h208, 1'b0,32'd7);
      add(1'b1,1'b1,1'b1,32'h300,      1'b1, 32'h208,      32'h0,           1'b0,32'h0,   1'b1,32'd8);
      add(1'b1,1'b1,1'b1,32'h404,      1'b0, 32'h404,      32'h0,           1'b0,32'h0,   1'b0,32'd8);
      add(1'b1,1'b1,1'b0,32'h0,        1'b0, 32'h408,      mem(32'h404),    1'b1,32'h408, 1'b0,32'd8);

      foreach (vt[i]) begin
         drive(vt[i].pw, vt[i].iw, vt[i].rv, vt[i].rpc, vt[i].st);
         step();
         chk($sformatf("v%0d_pc", i), PC, vt[i].e_pc);
         chk($sformatf("v%0d_addr", i), ICACHE_addr, vt[i].e_pc);
         chk($sformatf("v%0d_instr", i), IFID_Instr, vt[i].e_instr);
         chk($sformatf("v%0d_valid", i), {31'h0, IFID_Valid}, {31'h0, vt[i].e_v});
         if (vt[i].e_v) chk($sformatf("v%0d_p4", i), IFID_PCplus4, vt[i].e_p4);
         chk($sformatf("v%0d_fstall", i), {31'h0, fetch_stall}, {31'h0, vt[i].e_fs});
         chk($sformatf("v%0d_miss", i), miss_cycles, vt[i].e_miss);
      end

      // Reset while a redirect is pending: the pending target must be forgotten.
      drive(1'b1, 1'b1, 1'b1, 32'h500, 1'b1);
      step();
      chk("mr_fstall", {31'h0, fetch_stall}, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      rst = 1'b1;
      #1;
      chk("mr_ren_rst", {31'h0, ICACHE_ren}, 32'h0);
      step();
      chk("mr_rst_pc", PC, 32'h0);
      chk("mr_rst_fstall", {31'h0, fetch_stall}, 32'h0);
      chk("mr_rst_miss", miss_cycles, 32'h0);
      chk("mr_rst_valid", {31'h0, IFID_Valid}, 32'h0);
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      chk("mr_after_pc", PC, 32'h4);
      chk("mr_after_instr", IFID_Instr, mem(32'h0));
      chk("mr_after_valid", {31'h0, IFID_Valid}, 32'h1);

      // PC wrap at the top of the address space.
      drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
      step();
      chk("wrap_tgt_pc", PC, 32'hFFFF_FFFC);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      chk("wrap_pc", PC, 32'h0);
      chk("wrap_instr", IFID_Instr, mem(32'hFFFF_FFFC));
      chk("wrap_p4", IFID_PCplus4, 32'h0);
      chk("wrap_valid", {31'h0, IFID_Valid}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: it owns the PC register, drives the instruction-cache read port, and produces the IF/ID pipeline register consumed by decode and by hazard detection. It obeys the `PCWrite`/`IFIDWrite` hold requests from hazard detection and takes branch/jump redirects from ID. While an I-cache miss is outstanding it inserts bubbles so older instructions can drain. It remembers any redirect that arrives during the miss.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PCWrite`  in  1  from hazard detection; 0 = hold PC.
- `IFIDWrite`  in  1  from hazard detection; 0 = hold IF/ID register.
- `redirect_valid`  in  1  taken branch or jump resolved in ID this cycle.
- `redirect_pc`  in  32  target address; bits [1:0] are ignored and treated as 0.
- `ICACHE_ren`  out  1  I-cache read request.
- `ICACHE_addr`  out  32  I-cache read address; always equals `PC`.
- `ICACHE_stall`  in  1  1 = `ICACHE_rdata` is not valid this cycle.
- `ICACHE_rdata`  in  32  instruction word; valid when `ICACHE_stall`=0.
- `PC`  out  32  current fetch PC.
- `IFID_Instr`  out  32  registered instruction; 32'h0 (NOP) when bubble.
- `IFID_PCplus4`  out  32  registered PC+4 of `IFID_Instr`.
- `IFID_Valid`  out  1  1 = `IFID_Instr` is a real instruction.
- `fetch_stall`  out  1  status output; 1 while the fetch FSM is in MISS or MISS_REDIR.
- `miss_cycles`  out  32  performance counter: cycles with `ICACHE_stall`=1 and `ICACHE_ren`=1.

## Operation
- **FSM states:**
  - RUN: fetching normally.
  - MISS: waiting on the I-cache, no redirect pending.
  - MISS_REDIR: waiting on the I-cache, redirect pending.
- **Pending register:** `pend_pc` (32 bits).
- **RUN, `ICACHE_stall`=0** (instruction accepted):
  - If `redirect_valid`: PC <= `redirect_pc` with [1:0] cleared. IF/ID <= bubble, overriding `IFIDWrite`=0.
  - Else if `IFIDWrite`=1: IF/ID <= {`ICACHE_rdata`, PC+4, Valid=1}.
  - Else: IF/ID holds.
  - PC: PC <= PC+4 only if `PCWrite`=1 and no redirect; otherwise it holds.
- **RUN, `ICACHE_stall`=1:**
  - PC holds.
  - Next state is MISS_REDIR (latching `pend_pc` <= `redirect_pc`) if `redirect_valid`, else MISS.
- **MISS / MISS_REDIR, general rules:**
  - PC holds; `ICACHE_addr` stays stable until the stall drops.
  - Each cycle, IF/ID <= bubble if `IFIDWrite`=1, else holds.
  - A `redirect_valid` in either state overwrites `pend_pc`, and the state becomes MISS_REDIR.
- **Stall drops in MISS** (`ICACHE_stall`=0): handled exactly as RUN with `ICACHE_stall`=0; next state RUN.
- **Stall drops in MISS_REDIR:**
  - `ICACHE_rdata` is discarded.
  - IF/ID <= bubble; PC <= `pend_pc` (or `redirect_pc` if `redirect_valid` is also asserted that cycle).
  - Next state RUN.
- **Arithmetic:** PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0.
- **Request:** `ICACHE_ren`=0 in any cycle with `rst`=1, else 1.
- **`miss_cycles`:** saturates at 32'hFFFF_FFFF and clears only on reset.

## Timing
- **Reset values** (one edge with `rst`=1):
  - `PC`=`RESET_PC`; FSM=RUN; `pend_pc`=0.
  - `IFID_Instr`=0, `IFID_PCplus4`=0, `IFID_Valid`=0.
  - `fetch_stall`=0, `miss_cycles`=0.
- **Reset mid-miss:** reset wins. The pending redirect is dropped and the FSM returns to RUN.
- **Fetch latency:** the instruction at address A (accepted with `ICACHE_stall`=0 in cycle n) is visible on `IFID_*` in cycle n+1.
- **Redirect latency:**
  - From RUN: a redirect asserted in cycle n gives `PC`=target in cycle n+1.
  - During a miss: `PC`=target in the cycle after `ICACHE_stall` falls.
- **Outputs:** `fetch_stall` and all `IFID_*` are registered. `ICACHE_addr` and `ICACHE_ren` are combinational from `PC`/`rst`.
- **Priority** (highest first): `rst` > `redirect_valid` / pending redirect > `ICACHE_stall` > `PCWrite`/`IFIDWrite` hold.
- **Load-use hold:** `PCWrite`=0 with `IFIDWrite`=0 and no miss freezes `PC` and IF/ID exactly, for any number of cycles.

## Test plan
- **Reset, then free run, no stalls, `RESET_PC`=0:** `PC` steps 0,4,8. `IFID_Instr` equals the word at the previous PC, with `IFID_PCplus4`=4,8.
- **Load-use hold:** `PCWrite`=`IFIDWrite`=0 for 2 cycles at PC=0x10. `PC` stays 0x10 and IF/ID unchanged. On release, `PC`=0x14 and the next `IFID_Instr` is the word at 0x10.
- **Taken branch in RUN:** `redirect_valid`=1 with `redirect_pc`=0x40 at PC=0x20 (hold inputs deasserted). Next cycle `PC`=0x40 and `IFID_Valid`=0. The cycle after, the instruction at 0x40 is valid.
- **3-cycle I-cache miss at 0x80 with `IFIDWrite`=1:** three bubbles enter IF/ID, `fetch_stall`=1 for 3 cycles, and `miss_cycles` increments by 3. Then the instruction at 0x80 is valid and `PC`=0x84.
- **Redirect mid-miss:** `redirect_pc`=0x200 in the 2nd cycle of a miss at 0x80. When the stall drops, the word at 0x80 never reaches IF/ID (`IFID_Valid`=0) and `PC`=0x200 next cycle.
- **Reset and wrap:** reset asserted during MISS_REDIR gives `PC`=`RESET_PC` and FSM=RUN. After reset, with PC=0xFFFF_FFFC and no stall, the next PC is 0x0.
